// File: rtl/grid_lane_serializer.sv
// Purpose: snapshot one lane of a flattened lane bus and shift it out MSB-first with an even-parity bit.
// Latency: first bit one cycle after accept; parity at +WIDTH+1; ready again at +WIDTH+2+GAP.
// Backpressure: req_ready only in IDLE; requests outside IDLE are ignored (no queuing).
module grid_lane_serializer #(
  parameter int LANES = 6,
  parameter int WIDTH = 32,
  parameter int SEL_W = 3,
  parameter int GAP   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*WIDTH-1:0] lane_data,
  input  logic                   req_valid,
  input  logic [SEL_W-1:0]       req_lane,
  output logic                   req_ready,
  input  logic                   err_clr,
  output logic                   ser_data,
  output logic                   ser_valid,
  output logic                   ser_first,
  output logic                   ser_last,
  output logic                   err_sel
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int GAP_W = $clog2(GAP + 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [SEL_W:0]   LANES_LIM = (SEL_W + 1)'(LANES);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               par_q, par_d;
  logic               ser_data_q, ser_data_d;
  logic               ser_valid_q, ser_valid_d;
  logic               ser_first_q, ser_first_d;
  logic               ser_last_q, ser_last_d;
  logic               err_q, err_d;

  logic               accept;
  logic               lane_ok;
  logic [WIDTH-1:0]   lane_word;

  // Ready is gated by reset so nothing is accepted while the block is held in reset.
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign lane_ok   = {1'b0, req_lane} < LANES_LIM;

  // Select the requested lane; out-of-range indices yield zero and are never captured.
  always_comb begin
    lane_word = '0;
    for (int k = 0; k < LANES; k++) begin
      if (req_lane == SEL_W'(k)) lane_word = lane_data[k*WIDTH +: WIDTH];
    end
  end

  // Next-state and next-output logic; serial outputs are computed one cycle ahead and registered.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    par_d       = par_q;
    ser_data_d  = 1'b0;
    ser_valid_d = 1'b0;
    ser_first_d = 1'b0;
    ser_last_d  = 1'b0;
    err_d       = err_clr ? 1'b0 : err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (lane_ok) begin
            // MSB goes out immediately; the shift register keeps the remaining bits.
            ser_data_d  = lane_word[WIDTH-1];
            ser_valid_d = 1'b1;
            ser_first_d = 1'b1;
            shift_d     = {lane_word[WIDTH-2:0], 1'b0};
            par_d       = lane_word[WIDTH-1];
            cnt_d       = CNT_W'(1);
            state_d     = S_SHIFT;
          end else begin
            // Bad index sets the sticky flag; it wins over a same-cycle clear.
            err_d = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        // cnt_q counts bits already presented, including the one on the pin now.
        ser_valid_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          ser_data_d = par_q;
          ser_last_d = 1'b1;
          state_d    = S_PAR;
        end else begin
          ser_data_d = shift_q[WIDTH-1];
          par_d      = par_q ^ shift_q[WIDTH-1];
          shift_d    = {shift_q[WIDTH-2:0], 1'b0};
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end
      S_PAR: begin
        if (GAP == 0) begin
          state_d = S_IDLE;
        end else begin
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset; reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      par_q       <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      par_q       <= par_d;
      ser_data_q  <= ser_data_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
      err_q       <= err_d;
    end
  end

  assign ser_data  = ser_data_q;
  assign ser_valid = ser_valid_q;
  assign ser_first = ser_first_q;
  assign ser_last  = ser_last_q;
  assign err_sel   = err_q;

endmodule
